// File: rtl/lift_car_sequencer_pkg.sv
// Shared lift encodings: action codes, sequencer state and field widths.
// Imported by the lift FSM and the car sequencer so both agree on encoding.
package lift_pkg;

  localparam int FLOOR_W = 2;
  localparam int TIMER_W = 4;

  typedef logic [1:0] action_t;

  localparam action_t ACT_IDLE = 2'b00;
  localparam action_t ACT_UP   = 2'b01;
  localparam action_t ACT_DOWN = 2'b10;
  localparam action_t ACT_DOOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_DOOR
  } seq_state_e;

endpackage

// File: rtl/lift_car_sequencer_if.sv
// Command handshake between the lift FSM (master) and the car sequencer.
// Action is only consumed on edges where Ready is high.
interface lift_cmd_if;
  import lift_pkg::*;

  action_t Action;
  logic    Ready;

  modport master (
    output Action,
    input  Ready
  );

  modport slave (
    input  Action,
    output Ready
  );

endinterface

// File: rtl/lift_car_sequencer_timer.sv
// Loadable down-counter that saturates at zero.
// Zero flags the final cycle of a timed phase.
module cycle_timer
  import lift_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Load,
  input  logic [W-1:0] Value,
  output logic         Zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else if (Load) begin
      cnt_q <= Value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign Zero = (cnt_q == '0);

endmodule

// File: rtl/lift_car_sequencer.sv
// Car sequencer: turns lift FSM actions into timed motor/door drive,
// tracks the current floor and pulses Fault on out-of-range moves.
module lift_car_sequencer
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS    = 3,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  lift_cmd_if.slave          cmd,
  output logic [FLOOR_W-1:0] Floor,
  output logic               MotorUp,
  output logic               MotorDown,
  output logic               DoorOpen,
  output logic               Fault
);

  localparam logic [FLOOR_W-1:0] TOP_FLOOR =
    FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD =
    TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD =
    TIMER_W'(DOOR_CYCLES - 1);

  seq_state_e         state_q;
  logic [FLOOR_W-1:0] floor_q;
  logic               fault_q;

  logic               idle;
  logic               at_top;
  logic               at_bot;
  logic               act_up;
  logic               act_dn;
  logic               act_door;
  logic               t_load;
  logic [TIMER_W-1:0] t_value;
  logic               t_zero;

  assign idle     = (state_q == ST_IDLE);
  assign at_top   = (floor_q == TOP_FLOOR);
  assign at_bot   = (floor_q == '0);
  assign act_up   = (cmd.Action == ACT_UP);
  assign act_dn   = (cmd.Action == ACT_DOWN);
  assign act_door = (cmd.Action == ACT_DOOR);

  // Timer is only loaded when a legal command leaves IDLE.
  always_comb begin
    t_load  = 1'b0;
    t_value = '0;
    if (idle) begin
      unique case (1'b1)
        act_up && !at_top: begin
          t_load  = 1'b1;
          t_value = TRAVEL_LOAD;
        end
        act_dn && !at_bot: begin
          t_load  = 1'b1;
          t_value = TRAVEL_LOAD;
        end
        act_door: begin
          t_load  = 1'b1;
          t_value = DOOR_LOAD;
        end
        default: ;
      endcase
    end
  end

  cycle_timer #(
    .W (TIMER_W)
  ) u_timer (
    .Clock (Clock),
    .Reset (Reset),
    .Load  (t_load),
    .Value (t_value),
    .Zero  (t_zero)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      floor_q <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          unique case (1'b1)
            act_up: begin
              if (at_top) fault_q <= 1'b1;
              else        state_q <= ST_MOVE_UP;
            end
            act_dn: begin
              if (at_bot) fault_q <= 1'b1;
              else        state_q <= ST_MOVE_DOWN;
            end
            act_door: state_q <= ST_DOOR;
            default: ;
          endcase
        end
        ST_MOVE_UP: begin
          if (t_zero) begin
            floor_q <= floor_q + FLOOR_W'(1);
            state_q <= ST_IDLE;
          end
        end
        ST_MOVE_DOWN: begin
          if (t_zero) begin
            floor_q <= floor_q - FLOOR_W'(1);
            state_q <= ST_IDLE;
          end
        end
        ST_DOOR: begin
          if (t_zero) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd.Ready = idle;
  assign Floor     = floor_q;
  assign MotorUp   = (state_q == ST_MOVE_UP);
  assign MotorDown = (state_q == ST_MOVE_DOWN);
  assign DoorOpen  = (state_q == ST_DOOR);
  assign Fault     = fault_q;

endmodule

// File: tb/tb_lift_car_sequencer.sv
// Random-command bench: transaction model feeds queues, monitor compares.
// Ends with a directed reset-during-move case.
module tb_lift_car_sequencer;
  import lift_pkg::*;

  localparam int NF = 3;
  localparam int TC = 8;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] floor;
  logic       mu, md, dopen, fault;

  lift_cmd_if cmd();

  lift_car_sequencer #(
    .NUM_FLOORS    (NF),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .Clock     (clk),
    .Reset     (rst_n),
    .cmd       (cmd),
    .Floor     (floor),
    .MotorUp   (mu),
    .MotorDown (md),
    .DoorOpen  (dopen),
    .Fault     (fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  // kind: 0 = up, 1 = down, 2 = door
  typedef struct {
    int kind;
    int dur;
    int fl;
  } busy_t;

  busy_t bq[$];
  int    fq[$];
  bit    m_en = 1'b0;
  int    m_floor = 0;
  int    m_busy = 0;

  // Transaction-level model: a command either starts a busy period of
  // known length or is rejected; nothing is accepted while busy.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_busy > 0) begin
        m_busy--;
      end else begin
        case (int'(cmd.Action))
          1: if (m_floor < NF - 1) begin
               m_floor++;
               bq.push_back('{0, TC, m_floor});
               m_busy = TC;
             end else fq.push_back(m_floor);
          2: if (m_floor > 0) begin
               m_floor--;
               bq.push_back('{1, TC, m_floor});
               m_busy = TC;
             end else fq.push_back(m_floor);
          3: begin
               bq.push_back('{2, DC, m_floor});
               m_busy = DC;
             end
          default: ;
        endcase
      end
    end
  end

  bit in_busy = 1'b0;
  int b_kind, b_len;
  bit b_mixed;

  always @(negedge clk) begin
    if (m_en) begin
      if (fault) begin
        if (fq.size() == 0) begin
          chk("fault_unexpected", 1, 0);
        end else begin
          chk("fault_floor", int'(floor), fq.pop_front());
        end
      end
      if (!cmd.Ready) begin
        int k;
        k = mu ? 0 : (md ? 1 : (dopen ? 2 : 3));
        chk("busy_onehot", int'(mu) + int'(md) + int'(dopen), 1);
        if (!in_busy) begin
          in_busy = 1'b1;
          b_kind  = k;
          b_len   = 1;
          b_mixed = 1'b0;
        end else begin
          b_len++;
          if (k != b_kind) b_mixed = 1'b1;
        end
      end else begin
        chk("idle_drive", int'(mu) + int'(md) + int'(dopen), 0);
        if (in_busy) begin
          in_busy = 1'b0;
          if (bq.size() == 0) begin
            chk("busy_unexpected", 1, 0);
          end else begin
            busy_t e;
            e = bq.pop_front();
            chk("busy_kind", b_kind, e.kind);
            chk("busy_len", b_len, e.dur);
            chk("busy_floor", int'(floor), e.fl);
            chk("busy_steady", int'(b_mixed), 0);
          end
        end
      end
    end
  end

  task automatic wait_ready(string name);
    for (int i = 0; i < 40; i++) begin
      if (cmd.Ready) return;
      @(negedge clk);
    end
    chk(name, int'(cmd.Ready), 1);
  endtask

  initial begin
    cmd.Action = ACT_IDLE;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(cmd.Ready), 1);
    chk("rst_floor", int'(floor), 0);
    chk("rst_drive", int'(mu) + int'(md) + int'(dopen), 0);
    chk("rst_fault", int'(fault), 0);
    rst_n = 1'b1;
    m_en  = 1'b1;

    for (int s = 0; s < 200; s++) begin
      int r, hold;
      r = $urandom_range(0, 9);
      hold = $urandom_range(1, 12);
      if (r < 2)      cmd.Action = ACT_IDLE;
      else if (r < 5) cmd.Action = ACT_UP;
      else if (r < 8) cmd.Action = ACT_DOWN;
      else            cmd.Action = ACT_DOOR;
      repeat (hold) @(negedge clk);
    end
    cmd.Action = ACT_IDLE;
    repeat (30) @(negedge clk);
    chk("drain_busyq", bq.size(), 0);
    chk("drain_faultq", fq.size(), 0);
    chk("drain_inbusy", int'(in_busy), 0);
    chk("model_floor", int'(floor), m_floor);
    m_en = 1'b0;

    // Home the car, climb to floor 1, then reset part-way up to 2.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmd.Action = ACT_UP;
    @(negedge clk);
    cmd.Action = ACT_IDLE;
    wait_ready("climb_timeout");
    @(negedge clk);
    chk("climb_floor", int'(floor), 1);
    cmd.Action = ACT_UP;
    @(negedge clk);
    cmd.Action = ACT_IDLE;
    repeat (2) @(negedge clk);
    chk("mid_motor", int'(mu), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_motor", int'(mu), 0);
    chk("arst_floor", int'(floor), 0);
    chk("arst_ready", int'(cmd.Ready), 1);
    chk("arst_fault", int'(fault), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
